// File: rtl/mux8_residue_extractor_pkg.sv
// Shared constants for the mux8 residue extractor: residue classes and canonical residue codes.
package mux_decomp_pkg;

  localparam int SEL_W_DEF = 3;

  localparam logic [2:0] CLS_ZERO  = 3'd0;
  localparam logic [2:0] CLS_ONE   = 3'd1;
  localparam logic [2:0] CLS_D     = 3'd2;
  localparam logic [2:0] CLS_D_N   = 3'd3;
  localparam logic [2:0] CLS_E     = 3'd4;
  localparam logic [2:0] CLS_E_N   = 3'd5;
  localparam logic [2:0] CLS_OTHER = 3'd6;

  // Residue bit i = f(d=i[1], e=i[0]), so d is high in the upper half and e on odd bits.
  localparam logic [3:0] CODE_ZERO = 4'h0;
  localparam logic [3:0] CODE_ONE  = 4'hF;
  localparam logic [3:0] CODE_D    = 4'hC;
  localparam logic [3:0] CODE_DN   = 4'h3;
  localparam logic [3:0] CODE_E    = 4'hA;
  localparam logic [3:0] CODE_EN   = 4'h5;

  function automatic int frame_bits(input int sel_w);
    return 1 << (sel_w + 2);
  endfunction

  function automatic int num_residues(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/mux8_residue_extractor_classifier.sv
// Maps a 4-bit residue truth table over (d,e) to the literal it can be wired as.
module residue_classifier
  import mux_decomp_pkg::*;
(
  input  logic [3:0] code,
  output logic [2:0] cls
);

  always_comb begin
    cls = CLS_OTHER;
    case (code)
      CODE_ZERO: cls = CLS_ZERO;
      CODE_ONE:  cls = CLS_ONE;
      CODE_D:    cls = CLS_D;
      CODE_DN:   cls = CLS_D_N;
      CODE_E:    cls = CLS_E;
      CODE_EN:   cls = CLS_E_N;
      default:   cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/mux8_residue_extractor.sv
// Collects a serial 32-bit truth table and emits one classified (d,e) residue per mux select value.
module mux8_residue_extractor
  import mux_decomp_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [3:0]       out_code,
  output logic [2:0]       out_class,
  output logic             out_last,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int CNT_W = SEL_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       grp;
  logic             accept;
  logic             grp_end;
  logic             frame_end;
  logic             short_frame;
  logic             missing_last;
  logic             emit;
  logic [3:0]       next_code;
  logic [2:0]       next_class;

  // A completed group can only load when the output register is free, so the
  // stall decision uses registered state alone.
  assign in_ready     = !(out_valid && (cnt[1:0] == 2'd3));
  assign accept       = in_valid && in_ready;
  assign grp_end      = (cnt[1:0] == 2'd3);
  assign frame_end    = (cnt == CNT_MAX);
  assign short_frame  = accept && in_last && !frame_end;
  assign missing_last = accept && !in_last && frame_end;
  assign emit         = accept && grp_end && !short_frame;
  assign next_code    = {in_bit, grp};

  residue_classifier u_classifier (
    .code (next_code),
    .cls  (next_class)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      grp       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_code  <= '0;
      out_class <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= out_valid && out_ready && out_last;

      if (short_frame || missing_last) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      // A premature in_last drops the partial frame and realigns to m=0.
      if (short_frame) begin
        cnt <= '0;
        grp <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        case (cnt[1:0])
          2'd0:    grp[0] <= in_bit;
          2'd1:    grp[1] <= in_bit;
          2'd2:    grp[2] <= in_bit;
          default: ;
        endcase
      end

      if (emit) begin
        out_valid <= 1'b1;
        out_sel   <= cnt[CNT_W-1:2];
        out_code  <= next_code;
        out_class <= next_class;
        out_last  <= &cnt[CNT_W-1:2];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
